// File: rtl/fact_ctrl_seq.sv
// Factorial control/datapath sequencer: accepts n on go, iterates a multiply
// loop steered by the external comparator, and reports n! with done/err.
// Optional cycle counter output enabled by defining FACT_CYCLE_CNT_EN.
module fact_ctrl_seq #(
    parameter int RES_W = 32,
    parameter int N_MAX = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       n,
    output logic [3:0]       cnt_out,
    input  logic             cmp_le,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RES_W-1:0] result
`ifdef FACT_CYCLE_CNT_EN
    ,
    output logic [7:0]       cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MULT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] N_MAX_L = 5'(N_MAX);

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [RES_W-1:0] product_reg, product_next;
    logic [RES_W-1:0] result_reg, result_next;
    logic             err_reg, err_next;
    logic             n_ok;
    logic             accept;

    assign n_ok   = ({1'b0, n} <= N_MAX_L);
    assign accept = (state_reg == S_IDLE) && go;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 4'd0;
            product_reg <= '0;
            result_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            result_reg  <= result_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        result_next  = result_reg;
        err_next     = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    if (n_ok) begin
                        cnt_next     = n;
                        product_next = RES_W'(1);
                        err_next     = 1'b0;
                        state_next   = S_CHECK;
                    end else begin
                        err_next    = 1'b1;
                        result_next = '0;
                        state_next  = S_DONE;
                    end
                end
            end
            S_CHECK: begin
                // cmp_le comes from the external comparator (cnt_out <= 1)
                if (cmp_le) begin
                    result_next = product_reg;
                    state_next  = S_DONE;
                end else begin
                    state_next = S_MULT;
                end
            end
            S_MULT: begin
                product_next = product_reg * RES_W'(cnt_reg);
                cnt_next     = cnt_reg - 4'd1;
                state_next   = S_CHECK;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef FACT_CYCLE_CNT_EN
    logic [7:0] cycles_reg, cycles_next;

    // The accepting cycle counts as the first busy cycle; DONE itself is
    // counted by the increment on the edge that enters it.
    always_comb begin
        cycles_next = cycles_reg;
        if (accept) begin
            cycles_next = 8'd1;
        end else if ((state_reg == S_CHECK || state_reg == S_MULT) &&
                     cycles_reg != 8'hFF) begin
            cycles_next = cycles_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_reg <= 8'd0;
        end else begin
            cycles_reg <= cycles_next;
        end
    end

    assign cycles = cycles_reg;
`else
    logic accept_unused;
    assign accept_unused = accept;
`endif

    assign cnt_out = cnt_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign err     = err_reg;
    assign result  = result_reg;

endmodule

// File: tb/tb_fact_ctrl_seq.sv
// Scoreboard bench for fact_ctrl_seq: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever done is seen.
module tb_fact_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [3:0]  n;
    logic [3:0]  cnt_out;
    logic        cmp_le;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
`ifdef FACT_CYCLE_CNT_EN
    logic [7:0]  cycles;
`endif

    always #5 clk = ~clk;

    // Comparator stage with B tied to 1
    assign cmp_le = (cnt_out <= 4'd1);

    fact_ctrl_seq #(.RES_W(32), .N_MAX(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .n       (n),
        .cnt_out (cnt_out),
        .cmp_le  (cmp_le),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
`ifdef FACT_CYCLE_CNT_EN
        ,
        .cycles  (cycles)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          done_cyc;
        int          cyc_cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] fact_tab [0:12];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue go for one cycle; optionally queue the expected completion.
    task automatic start(input logic [3:0] nv, input bit push);
        exp_t e;
        int   lat;
        go = 1'b1;
        n  = nv;
        tick();
        go = 1'b0;
        if (push) begin
            if (nv > 4'd12) begin
                lat   = 0;
                e.res = 32'd0;
                e.err = 1'b1;
            end else begin
                lat   = (nv == 4'd0) ? 1 : 2 * int'(nv) - 1;
                e.res = fact_tab[nv];
                e.err = 1'b0;
            end
            e.done_cyc = cyc + lat;
            e.cyc_cnt  = lat + 1;
            q.push_back(e);
            $display("issue n=%0d exp_result=%0d exp_err=%0d done_cycle=%0d", nv, e.res, e.err, e.done_cyc);
        end else begin
            $display("issue n=%0d (expected to be aborted)", nv);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        chk("drain_pending", 64'(q.size()), 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("done cycle=%0d result=%0d err=%0d", cyc, result, err);
                chk("result", 64'(result), 64'(e.res));
                chk("err", {63'd0, err}, {63'd0, e.err});
                chk("latency", 64'(cyc), 64'(e.done_cyc));
`ifdef FACT_CYCLE_CNT_EN
                chk("cycles", 64'(cycles), 64'(e.cyc_cnt));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fact_tab[0]  = 32'd1;        fact_tab[1]  = 32'd1;
        fact_tab[2]  = 32'd2;        fact_tab[3]  = 32'd6;
        fact_tab[4]  = 32'd24;       fact_tab[5]  = 32'd120;
        fact_tab[6]  = 32'd720;      fact_tab[7]  = 32'd5040;
        fact_tab[8]  = 32'd40320;    fact_tab[9]  = 32'd362880;
        fact_tab[10] = 32'd3628800;  fact_tab[11] = 32'd39916800;
        fact_tab[12] = 32'h1C8CFC00;

        rst = 1'b1; go = 1'b0; n = 4'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_cnt", 64'(cnt_out), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
`ifdef FACT_CYCLE_CNT_EN
        chk("rst_cycles", 64'(cycles), 64'd0);
`endif

        start(4'd5, 1'b1);  drain();
        start(4'd0, 1'b1);  drain();
        start(4'd1, 1'b1);  drain();

        start(4'd12, 1'b1);
        for (int k = 12; k >= 1; k--) begin
            chk("cnt_seq", 64'(cnt_out), 64'(k));
            tick(); tick();
        end
        drain();

        start(4'd13, 1'b1); drain();
        start(4'd3, 1'b1);
        chk("err_cleared_at_accept", {63'd0, err}, 64'd0);
        chk("result_held_at_accept", 64'(result), 64'd0);
        drain();

        // go while busy must be ignored and n not re-sampled
        start(4'd6, 1'b1);
        tick(); tick();
        go = 1'b1; n = 4'd2; tick(); go = 1'b0;
        tick(); tick(); tick();
        go = 1'b1; n = 4'd2; tick(); go = 1'b0;
        drain();

        // reset mid-run discards the operation
        start(4'd9, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_cnt", 64'(cnt_out), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_err", {63'd0, err}, 64'd0);
        for (int i = 0; i < 25; i++) tick();

        // rst and go together: go is not accepted
        rst = 1'b1; go = 1'b1; n = 4'd3; tick();
        rst = 1'b0; go = 1'b0; tick();
        chk("rst_beats_go", {63'd0, busy}, 64'd0);

        // go held high restarts in the IDLE cycle after DONE
        begin
            exp_t e;
            go = 1'b1; n = 4'd2; tick();
            e.res = 32'd2; e.err = 1'b0; e.cyc_cnt = 4;
            e.done_cyc = cyc + 3; q.push_back(e);
            e.done_cyc = cyc + 8; q.push_back(e);
            $display("issue held go n=2 twice, done cycles=%0d,%0d", cyc + 3, cyc + 8);
            for (int i = 0; i < 5; i++) tick();
            go = 1'b0;
            drain();
        end

        tick(); tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
